// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Holds the buffered fetch entry and the inflight lookup tracker.
package fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam int          DEF_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } inflight_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} pairs.
// Flush beats push; the head entry is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(BUF_DEPTH):0] count,
    output fetch_entry_t               head
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [BUF_DEPTH];
    fetch_entry_t  mem_d [BUF_DEPTH];
    logic          do_pop;
    logic          do_push;

    // Next-state pointers, occupancy and storage write.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q < CW'(BUF_DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: sequential PC generation, miss re-issue, redirect squash.
// Fetched pairs are buffered so decode back-pressure never drops one.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          BUF_DEPTH = DEF_BUF_DEPTH,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic [31:0] ic_instr,
    input  logic        ic_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [15:0] miss_cnt
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]   fpc_q, fpc_d;
    inflight_t     infl_q, infl_d;
    logic [15:0]   miss_cnt_q, miss_cnt_d;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;
    logic          room;
    logic          req;
    logic [31:0]   addr;
    logic [CW:0]   occ;

    // Address select: redirect, then miss re-issue, then sequential if room.
    always_comb begin
        fpc_d      = fpc_q;
        infl_d     = '0;
        miss_cnt_d = miss_cnt_q;
        req        = 1'b0;
        addr       = fpc_q;
        push       = infl_q.valid && ic_valid && !redirect_valid;
        pop        = (count != '0) && id_ready;
        push_data  = '{pc: infl_q.pc, instr: ic_instr};
        occ        = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(push);
        room       = occ < (CW+1)'(BUF_DEPTH);
        if (redirect_valid) begin
            addr   = align_word(redirect_pc);
            req    = 1'b1;
            fpc_d  = addr + 32'd4;
            infl_d = '{pc: addr, valid: 1'b1};
        end else if (infl_q.valid && !ic_valid) begin
            addr   = infl_q.pc;
            req    = 1'b1;
            fpc_d  = infl_q.pc + 32'd4;
            infl_d = infl_q;
            if (miss_cnt_q != 16'hFFFF) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end else if (room) begin
            addr   = fpc_q;
            req    = 1'b1;
            fpc_d  = fpc_q + 32'd4;
            infl_d = '{pc: fpc_q, valid: 1'b1};
        end
    end

    // Fetch PC, inflight tracker and miss counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            infl_q     <= '0;
            miss_cnt_q <= '0;
        end else begin
            fpc_q      <= fpc_d;
            infl_q     <= infl_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    // No lookup may leave while reset is held.
    assign ic_req   = rst_n && req;
    assign ic_addr  = addr;
    assign id_valid = (count != '0);
    assign id_instr = id_valid ? head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? head.pc : 32'h0;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: bench acts as a 1-cycle I-cache,
// expected program-order stream is queued and checked on every pop.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_instr = '0;
    logic        ic_valid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [15:0] miss_cnt;

    int tests = 0;
    int fails = 0;
    int delivered = 0;

    logic [31:0] exp_q[$];
    logic [31:0] tail_pc = RST_PC;
    logic        prev_req = 1'b0;
    logic        prev_redir = 1'b0;
    logic [31:0] prev_addr = '0;
    int          model_miss = 0;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_instr       (ic_instr),
        .ic_valid       (ic_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(tail_pc);
            tail_pc = tail_pc + 32'd4;
        end
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                tail_pc    = RST_PC;
                refill();
                model_miss = 0;
                prev_req   = 1'b0;
                prev_redir = 1'b0;
                prev_addr  = '0;
            end else begin
                if (prev_redir) chk("flush_empty", 32'(id_valid), 32'd0);
                chk("miss_cnt", 32'(miss_cnt), 32'(model_miss));
                if (redirect_valid) begin
                    chk("redir_req", 32'(ic_req), 32'd1);
                    chk("redir_addr", ic_addr, {redirect_pc[31:2], 2'b00});
                end else if (prev_req && !ic_valid) begin
                    chk("reissue_req", 32'(ic_req), 32'd1);
                    chk("reissue_addr", ic_addr, prev_addr);
                end
                if (id_valid && id_ready) begin
                    e = exp_q.pop_front();
                    refill();
                    chk("pop_pc", id_pc, e);
                    chk("pop_instr", id_instr, mem(e));
                    delivered++;
                end else if (!id_valid) begin
                    chk("empty_pc", id_pc, 32'd0);
                    chk("empty_instr", id_instr, NOP);
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    tail_pc = {redirect_pc[31:2], 2'b00};
                    refill();
                end
                if (prev_req && !ic_valid && !redirect_valid && model_miss < 65535)
                    model_miss++;
                prev_req   = ic_req;
                prev_addr  = ic_addr;
                prev_redir = redirect_valid;
            end
        end
    end

    task automatic step(input bit v, input bit rdy, input bit rd,
                        input logic [31:0] rpc);
        @(posedge clk);
        #1;
        ic_valid       = v;
        ic_instr       = v ? mem(prev_addr) : 32'hDEAD_BEEF;
        id_ready       = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        #2;
    endtask

    task automatic do_reset(input bit rdy);
        rst_n          = 1'b0;
        ic_valid       = 1'b0;
        ic_instr       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = rdy;
        #1;
        chk("rst_req", 32'(ic_req), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, NOP);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        chk("rel_addr", ic_addr, RST_PC);
        chk("rel_req", 32'(ic_req), 32'd1);
    endtask

    initial begin
        int d0;
        #2;
        // Straight-line fetch, always hit, decode always ready.
        do_reset(1'b1);
        step(1, 1, 0, 0);
        chk("seq_addr1", ic_addr, 32'h104);
        step(1, 1, 0, 0);
        chk("seq_addr2", ic_addr, 32'h108);
        chk("seq_pc0", id_pc, 32'h100);
        chk("seq_instr0", id_instr, mem(32'h100));
        step(1, 1, 0, 0);
        chk("seq_pc1", id_pc, 32'h104);

        // Three misses on 0x104.
        do_reset(1'b1);
        step(1, 1, 0, 0);
        chk("miss_addr_c1", ic_addr, 32'h104);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("miss_addr_hold", ic_addr, 32'h104);
        end
        step(1, 1, 0, 0);
        chk("miss_addr_next", ic_addr, 32'h108);
        chk("miss_cnt3", 32'(miss_cnt), 32'd3);

        // Back-pressure with two-entry buffer.
        do_reset(1'b0);
        step(1, 0, 0, 0);
        chk("bp_addr1", ic_addr, 32'h104);
        step(1, 0, 0, 0);
        chk("bp_req_drop", 32'(ic_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0);
            chk("bp_req_low", 32'(ic_req), 32'd0);
            chk("bp_hold_pc", id_pc, 32'h100);
            chk("bp_valid", 32'(id_valid), 32'd1);
        end
        step(1, 1, 0, 0);
        chk("bp_drain0", id_pc, 32'h100);
        chk("bp_resume", ic_addr, 32'h108);
        step(1, 1, 0, 0);
        chk("bp_drain1", id_pc, 32'h104);
        step(1, 1, 0, 0);
        chk("bp_drain2", id_pc, 32'h108);

        // Redirect while buffered and inflight.
        do_reset(1'b0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h2003);
        chk("redir_target", ic_addr, 32'h2000);
        step(1, 0, 0, 0);
        chk("redir_flushed", 32'(id_valid), 32'd0);
        step(1, 0, 0, 0);
        chk("redir_head", id_pc, 32'h2000);
        chk("redir_instr", id_instr, mem(32'h2000));

        // Address wrap.
        step(1, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_target", ic_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        chk("wrap_next", ic_addr, 32'h0);
        step(1, 1, 0, 0);
        chk("wrap_head", id_pc, 32'hFFFF_FFFC);

        // Async reset in the middle of a miss.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("pre_rst_miss", 32'(miss_cnt), 32'd2);
        @(posedge clk);
        #3;
        do_reset(1'b1);

        // Randomized traffic against the scoreboard.
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 7, ($urandom % 10) < 6,
                 ($urandom % 100) < 4, $urandom);
        end
        chk("throughput", 32'(delivered - d0 > 300), 32'd1);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
